// File: rtl/rect_draw_ctrl.sv
// Rectangle-render controller: operator enters X, Y, W, H with `enable`, then `draw`
// raster-scans the rectangle, emitting registered plot requests with edge clipping.
module rect_draw_ctrl #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               draw,
  input  logic [X_W-1:0]     data_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               outline,
  output logic               plot,
  output logic [X_W-1:0]     plot_x,
  output logic [Y_W-1:0]     plot_y,
  output logic [COLOR_W-1:0] plot_color,
  output logic               busy,
  output logic               done
);

  typedef enum logic [3:0] {
    S_LOAD_X    = 4'd0,
    S_WAIT_X    = 4'd1,
    S_LOAD_Y    = 4'd2,
    S_WAIT_Y    = 4'd3,
    S_LOAD_W    = 4'd4,
    S_WAIT_W    = 4'd5,
    S_LOAD_H    = 4'd6,
    S_WAIT_H    = 4'd7,
    S_WAIT_DRAW = 4'd8,
    S_DRAW      = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t             state_q;
  logic [X_W-1:0]     x_q, w_q, cx_q;
  logic [Y_W-1:0]     y_q, h_q, cy_q;
  logic [COLOR_W-1:0] color_q;
  logic               outline_q;
  logic               plot_q;
  logic [X_W-1:0]     plot_x_q;
  logic [Y_W-1:0]     plot_y_q;
  logic [COLOR_W-1:0] plot_color_q;

  // One extra bit on each sum so off-screen pixels never wrap back on-screen.
  logic [X_W:0] pix_x_d;
  logic [Y_W:0] pix_y_d;
  logic         last_col_d, last_row_d, edge_d, plot_d;

  assign pix_x_d    = {1'b0, x_q} + {1'b0, cx_q};
  assign pix_y_d    = {1'b0, y_q} + {1'b0, cy_q};
  assign last_col_d = (cx_q == w_q - X_W'(1));
  assign last_row_d = (cy_q == h_q - Y_W'(1));
  assign edge_d     = (cx_q == '0) || last_col_d || (cy_q == '0) || last_row_d;
  assign plot_d     = (pix_x_d < SCR_W) && (pix_y_d < SCR_H) && (!outline_q || edge_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD_X;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      color_q      <= '0;
      outline_q    <= 1'b0;
      plot_q       <= 1'b0;
      plot_x_q     <= '0;
      plot_y_q     <= '0;
      plot_color_q <= '0;
    end else begin
      plot_q <= 1'b0;
      case (state_q)
        S_LOAD_X: begin
          x_q <= data_in;
          if (enable) state_q <= S_WAIT_X;
        end
        S_WAIT_X: if (!enable) state_q <= S_LOAD_Y;
        S_LOAD_Y: begin
          y_q <= data_in[Y_W-1:0];
          if (enable) state_q <= S_WAIT_Y;
        end
        S_WAIT_Y: if (!enable) state_q <= S_LOAD_W;
        S_LOAD_W: begin
          w_q <= data_in;
          if (enable) state_q <= S_WAIT_W;
        end
        S_WAIT_W: if (!enable) state_q <= S_LOAD_H;
        S_LOAD_H: begin
          h_q <= data_in[Y_W-1:0];
          if (enable) state_q <= S_WAIT_H;
        end
        S_WAIT_H: if (!enable) state_q <= S_WAIT_DRAW;
        S_WAIT_DRAW: begin
          if (draw) begin
            color_q   <= color_in;
            outline_q <= outline;
            cx_q      <= '0;
            cy_q      <= '0;
            state_q   <= (w_q != '0 && h_q != '0) ? S_DRAW : S_DONE;
          end
        end
        S_DRAW: begin
          // Every visit costs a cycle; clipped/interior pixels just drop the strobe.
          plot_q       <= plot_d;
          plot_x_q     <= pix_x_d[X_W-1:0];
          plot_y_q     <= pix_y_d[Y_W-1:0];
          plot_color_q <= color_q;
          if (last_col_d) begin
            cx_q <= '0;
            if (last_row_d) state_q <= S_DONE;
            else            cy_q    <= cy_q + Y_W'(1);
          end else begin
            cx_q <= cx_q + X_W'(1);
          end
        end
        S_DONE:  state_q <= S_LOAD_X;
        default: state_q <= S_LOAD_X;
      endcase
    end
  end

  assign plot       = plot_q;
  assign plot_x     = plot_x_q;
  assign plot_y     = plot_y_q;
  assign plot_color = plot_color_q;
  assign busy       = (state_q == S_DRAW);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_rect_draw_ctrl.sv
// Directed bench for rect_draw_ctrl: fill, outline, clip, zero size, enable handshake, reset abort.
module tb_rect_draw_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, draw, outline;
  logic [7:0] data_in;
  logic [2:0] color_in;
  logic       plot, busy, done;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_color;
  logic       lp;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  rect_draw_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .draw(draw), .data_in(data_in),
    .color_in(color_in), .outline(outline), .plot(plot), .plot_x(plot_x),
    .plot_y(plot_y), .plot_color(plot_color), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_field(input logic [7:0] v);
    data_in = v; enable = 1'b0; tick;
    enable = 1'b1; tick;
    enable = 1'b0; tick;
  endtask

  task automatic load_fields(input int x, input int y, input int w, input int h);
    load_field(8'(x)); load_field(8'(y)); load_field(8'(w)); load_field(8'(h));
  endtask

  // n counts cycles after the draw cycle: visit k shows at n=k+2, done at n=W*H+1.
  task automatic run_draw(input int x, input int y, input int w, input int h,
                          input logic [2:0] col, input logic outl,
                          input int exp_plots, input int exp_done, output logic last_plot);
    int  plots, busys, done_at, k, cx, cy;
    bit  got_done, exp_ok;
    color_in = col; outline = outl; draw = 1'b1;
    plots = 0; busys = 0; got_done = 0; done_at = 0; last_plot = 1'b0;
    for (int n = 1; n <= 400 && !got_done; n++) begin
      tick;
      draw = 1'b0;
      if (busy) busys++;
      if (plot) begin
        k  = n - 2;
        chk("pix_inrange", 32'(k >= 0 && k < w*h), 1);
        cx = (w > 0) ? k % w : 0;
        cy = (w > 0) ? k / w : 0;
        exp_ok = (x + cx < 160) && (y + cy < 120) &&
                 (!outl || cx == 0 || cx == w-1 || cy == 0 || cy == h-1);
        chk("pix_ok", 32'(plot), 32'(exp_ok));
        chk("pix_x", 32'(plot_x), 32'(x + cx));
        chk("pix_y", 32'(plot_y), 32'(y + cy));
        chk("pix_color", 32'(plot_color), 32'(col));
        plots++;
      end
      if (done) begin
        got_done  = 1;
        done_at   = n;
        last_plot = plot;
        chk("done_cyc", 32'(n), 32'(exp_done));
      end
    end
    if (!got_done) chk("done_seen", 0, 1);
    chk("plots", 32'(plots), 32'(exp_plots));
    chk("busy_cyc", 32'(busys), 32'(w*h));
    tick;
    chk("done_pulse", 32'(done), 0);
    chk("state_ret", 32'(dut.state_q), 0);
    $display("draw x=%0d y=%0d w=%0d h=%0d outline=%0d plots=%0d done_at=%0d",
             x, y, w, h, outl, plots, done_at);
  endtask

  initial begin
    int plots, dones;
    reset = 1'b1; enable = 1'b0; draw = 1'b0; outline = 1'b0;
    data_in = '0; color_in = '0;
    tick; tick;
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_px", 32'(plot_x), 0);
    chk("rst_py", 32'(plot_y), 0);
    chk("rst_pc", 32'(plot_color), 0);
    chk("rst_state", 32'(dut.state_q), 0);
    reset = 1'b0;
    tick;

    load_fields(10, 20, 4, 3);
    run_draw(10, 20, 4, 3, 3'd5, 1'b0, 12, 13, lp);
    chk("fill_last_with_done", 32'(lp), 1);

    load_fields(10, 20, 4, 3);
    run_draw(10, 20, 4, 3, 3'd5, 1'b1, 10, 13, lp);

    load_fields(158, 118, 4, 4);
    run_draw(158, 118, 4, 4, 3'd2, 1'b0, 4, 17, lp);

    load_fields(7, 7, 0, 5);
    run_draw(7, 7, 0, 5, 3'd3, 1'b0, 0, 1, lp);

    // X captured before enable rises must survive a long held enable with changing data.
    data_in = 8'd33; enable = 1'b0; tick;
    enable = 1'b1; tick;
    for (int i = 0; i < 50; i++) begin
      data_in = 8'(100 + i);
      tick;
    end
    enable = 1'b0; tick;
    chk("hs_state_y", 32'(dut.state_q), 2);
    data_in = 8'd50; draw = 1'b1; tick;
    draw = 1'b0;
    chk("hs_draw_ign_busy", 32'(busy), 0);
    chk("hs_draw_ign_plot", 32'(plot), 0);
    enable = 1'b1; tick;
    enable = 1'b0; tick;
    load_field(8'd1); load_field(8'd1);
    run_draw(33, 50, 1, 1, 3'd6, 1'b0, 1, 2, lp);
    $display("handshake x_hold done");

    load_fields(10, 20, 4, 3);
    color_in = 3'd5; outline = 1'b0; draw = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick;
      draw = 1'b0;
    end
    chk("abort_busy_pre", 32'(busy), 1);
    reset = 1'b1; tick;
    chk("abort_plot", 32'(plot), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_state", 32'(dut.state_q), 0);
    chk("abort_x", 32'(dut.x_q), 0);
    chk("abort_y", 32'(dut.y_q), 0);
    chk("abort_w", 32'(dut.w_q), 0);
    chk("abort_h", 32'(dut.h_q), 0);
    reset = 1'b0;
    plots = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (plot) plots++;
      if (done) dones++;
    end
    chk("abort_no_plot", 32'(plots), 0);
    chk("abort_no_done", 32'(dones), 0);
    $display("reset abort done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_draw_ctrl.md
# rect_draw_ctrl

Parametrised rectangle-render controller for the VGA plot path. The operator steps through four fields with `enable`: X origin, Y origin, width, height. Asserting `draw` then starts an internal raster scan that emits one plot request per cycle to the framebuffer writer. Compared with the fixed-size box controller, it adds:
- run-time width and height;
- fill/outline mode;
- screen-edge clipping;
- a `busy`/`done` handshake.

## Interface
Parameters:
- `X_W`, 8, width of X coordinate, width field and `data_in`
- `Y_W`, 7, width of Y coordinate and height field (`Y_W <= X_W`)
- `COLOR_W`, 3, colour width
- `SCREEN_W`, 160, visible columns; pixels with x >= SCREEN_W are clipped
- `SCREEN_H`, 120, visible rows; pixels with y >= SCREEN_H are clipped

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  field-step strobe (level, debounced button)
- `draw`  in  1  start-draw request (level)
- `data_in`  in  X_W  field value; Y and H use bits [Y_W-1:0]
- `color_in`  in  COLOR_W  colour, latched at draw start
- `outline`  in  1  0 = filled, 1 = outline only; latched at draw start
- `plot`  out  1  framebuffer write enable
- `plot_x`  out  X_W  pixel column
- `plot_y`  out  Y_W  pixel row
- `plot_color`  out  COLOR_W  pixel colour
- `busy`  out  1  high while in DRAW
- `done`  out  1  one-cycle pulse at end of each draw command

## Operation
States: LOAD_X, WAIT_X, LOAD_Y, WAIT_Y, LOAD_W, WAIT_W, LOAD_H, WAIT_H, WAIT_DRAW, DRAW, DONE.

Field loading:
- Each LOAD_f state loads field register f from `data_in` every cycle.
- LOAD_f -> WAIT_f when `enable`=1. The held value is the `data_in` from the last LOAD_f cycle.
- WAIT_f -> next LOAD state when `enable`=0. Holding `enable` high stays in WAIT_f indefinitely.
- WAIT_H -> WAIT_DRAW when `enable`=0.

Draw start:
- From WAIT_DRAW, when `draw`=1:
  - latch `color_in` and `outline`;
  - clear column counter cx and row counter cy;
  - go to DRAW if W!=0 and H!=0, else go straight to DONE.

Raster scan:
- DRAW visits one pixel (cx,cy) per cycle in row-major order.
- cx wraps W-1 -> 0 and increments cy.
- After visiting (W-1,H-1), the next state is DONE.
- DONE lasts one cycle, then goes to LOAD_X. Field registers hold their values, so a repeat draw only needs re-entry of the fields the operator changes.

Pixel address and plot condition:
- px = X + cx, computed in X_W+1 bits. py = Y + cy, computed in Y_W+1 bits. No wrap.
- A visited pixel is plotted iff all of the following hold:
  - px < SCREEN_W;
  - py < SCREEN_H;
  - `outline`=0, or cx==0, or cx==W-1, or cy==0, or cy==H-1.
- Clipped and interior pixels still consume a cycle; scan length is always W*H cycles.

Outputs:
- `busy` = (state==DRAW), combinational.
- `done` = (state==DONE), combinational.
- `draw` is ignored outside WAIT_DRAW. `enable` is ignored in WAIT_DRAW, DRAW and DONE.

## Timing
Reset behaviour:
- State goes to LOAD_X.
- Fields, counters and latched colour/mode clear to 0.
- `plot`, `plot_x`, `plot_y`, `plot_color`, `busy` and `done` are all 0 the cycle after reset is sampled.
- Reset mid-DRAW aborts immediately: no further plots, no `done` pulse.

Plot output latency:
- `plot`, `plot_x`, `plot_y` and `plot_color` are registered, with 1-cycle latency from the visit.
- A pixel visited in cycle n appears at the outputs in cycle n+1. `plot` is 0 in every other cycle.
- The last visited pixel appears in the same cycle as `done`=1.

Command latency:
- `draw` sampled high in WAIT_DRAW at edge t: DRAW from t+1, first plot output at t+2.
- Total command latency is W*H+1 cycles from `draw` to `done`.
- With W=0 or H=0: `done` is high in cycle t+1 and `plot` never asserts.

Maximum size: W = 2^X_W-1 and H = 2^Y_W-1 must scan without counter overflow.

## Test plan
- Fill: X=10, Y=20, W=4, H=3, colour 5, `draw` -> 12 plots on consecutive cycles, (10,20)..(13,20), (10,21).., ending (13,22), all colour 5; `done` coincides with the last plot; `busy` high for 12 cycles.
- Outline: same fields with `outline`=1 -> 10 plots; (11,21) and (12,21) absent; `done` still 13 cycles after `draw`.
- Clip: X=158, Y=118, W=4, H=4 -> only (158,118), (159,118), (158,119), (159,119) plotted; `done` 17 cycles after `draw`.
- Zero size: W=0, H=5 -> `done` pulse one cycle after `draw`, no plot, then back in LOAD_X.
- Handshake: hold `enable` high 50 cycles in WAIT_X while `data_in` changes -> X keeps its first-captured value. `draw` pulsed during field entry -> ignored.
- Reset: assert `reset` on the 5th DRAW cycle of a 4x3 fill -> `plot`, `busy` and `done` are 0 from the next cycle; state is LOAD_X; all fields read 0.
